// File: rtl/calc_cmd_tx.sv
// rtl/calc_cmd_tx.sv - UART command transmitter sending operand A, operand B and op as 12 8N1 bytes
module calc_cmd_tx #(
  parameter int ticks_per_bit = 104,
  parameter int gap_ticks     = 104
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] a_in,
  input  logic [31:0] b_in,
  input  logic [3:0]  op_in,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        tx_out,
  output logic [3:0]  byte_idx
);

  localparam int MAX_TICKS = (ticks_per_bit > gap_ticks) ? ticks_per_bit : gap_ticks;
  localparam int TW        = $clog2(MAX_TICKS);
  localparam logic [TW-1:0] T_LAST = TW'(ticks_per_bit - 1);
  localparam logic [TW-1:0] G_LAST = TW'((gap_ticks > 0) ? gap_ticks - 1 : 0);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, GAP} state_t;

  state_t        state, state_next;
  logic [TW-1:0] tick;
  logic [2:0]    bit_cnt;
  logic [95:0]   shift_buf;
  logic [7:0]    cur_byte;
  logic [2:0]    bit_sel;
  logic          bit_end, gap_end, next_byte, done_next, tx_next;

  always_comb begin
    bit_end    = (tick == T_LAST);
    gap_end    = (tick == G_LAST);
    state_next = state;
    done_next  = 1'b0;
    next_byte  = 1'b0;
    cur_byte   = shift_buf[7:0];
    case (state)
      IDLE:  if (start) state_next = START;
      START: if (bit_end) state_next = DATA;
      DATA:  if (bit_end && bit_cnt == 3'd7) state_next = STOP;
      STOP: begin
        if (bit_end) begin
          if (byte_idx == 4'd11) begin
            state_next = IDLE;
            done_next  = 1'b1;
          end else if (gap_ticks > 0) begin
            state_next = GAP;
          end else begin
            state_next = START;
            next_byte  = 1'b1;
          end
        end
      end
      GAP: begin
        if (gap_end) begin
          state_next = START;
          next_byte  = 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase

    // tx_out is registered, so pick the bit that will be on the line after this edge
    bit_sel = (state == DATA) ? (bit_end ? bit_cnt + 3'd1 : bit_cnt) : 3'd0;
    case (state_next)
      START:   tx_next = 1'b0;
      DATA:    tx_next = cur_byte[bit_sel];
      default: tx_next = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      tick      <= '0;
      bit_cnt   <= 3'd0;
      byte_idx  <= 4'd0;
      shift_buf <= '0;
      tx_out    <= 1'b1;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      state  <= state_next;
      tx_out <= tx_next;
      done   <= done_next;
      busy   <= (state_next != IDLE);

      if (state == IDLE || state_next != state || (state == DATA && bit_end))
        tick <= '0;
      else
        tick <= tick + 1'b1;

      if (state == DATA && bit_end)
        bit_cnt <= bit_cnt + 3'd1;
      else if (state != DATA)
        bit_cnt <= 3'd0;

      if (state == IDLE && start) begin
        shift_buf <= {24'h0, 4'h0, op_in, b_in, a_in};
      end else if (next_byte) begin
        shift_buf <= {8'h00, shift_buf[95:8]};
        byte_idx  <= byte_idx + 4'd1;
      end

      if (done_next)
        byte_idx <= 4'd0;
    end
  end

endmodule

// File: tb/tb_calc_cmd_tx.sv
// tb/tb_calc_cmd_tx.sv - scoreboard bench for calc_cmd_tx across three bit/gap timings
module tb_calc_cmd_tx;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] a_in = '0;
  logic [31:0] b_in = '0;
  logic [3:0]  op_in = '0;
  logic        start0 = 1'b0, start1 = 1'b0, start2 = 1'b0;
  logic        busy0, busy1, busy2, done0, done1, done2, tx0, tx1, tx2;
  logic [3:0]  idx0, idx1, idx2;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int busy_cyc;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  calc_cmd_tx #(.ticks_per_bit(104), .gap_ticks(104)) dut0 (
    .clk(clk), .rst(rst), .a_in(a_in), .b_in(b_in), .op_in(op_in), .start(start0),
    .busy(busy0), .done(done0), .tx_out(tx0), .byte_idx(idx0));
  calc_cmd_tx #(.ticks_per_bit(4), .gap_ticks(0)) dut1 (
    .clk(clk), .rst(rst), .a_in(a_in), .b_in(b_in), .op_in(op_in), .start(start1),
    .busy(busy1), .done(done1), .tx_out(tx1), .byte_idx(idx1));
  calc_cmd_tx #(.ticks_per_bit(4), .gap_ticks(2)) dut2 (
    .clk(clk), .rst(rst), .a_in(a_in), .b_in(b_in), .op_in(op_in), .start(start2),
    .busy(busy2), .done(done2), .tx_out(tx2), .byte_idx(idx2));

  function automatic logic get_tx(input int sel);
    return (sel == 0) ? tx0 : (sel == 1) ? tx1 : tx2;
  endfunction
  function automatic logic get_busy(input int sel);
    return (sel == 0) ? busy0 : (sel == 1) ? busy1 : busy2;
  endfunction
  function automatic logic get_done(input int sel);
    return (sel == 0) ? done0 : (sel == 1) ? done1 : done2;
  endfunction
  function automatic logic [3:0] get_idx(input int sel);
    return (sel == 0) ? idx0 : (sel == 1) ? idx1 : idx2;
  endfunction

  task automatic set_start(input int sel, input logic v);
    if (sel == 0) start0 = v;
    else if (sel == 1) start1 = v;
    else start2 = v;
  endtask

  task automatic step(input int sel);
    @(negedge clk);
    if (get_busy(sel) === 1'b1) busy_cyc++;
  endtask

  task automatic push_frame(input logic [31:0] a, input logic [31:0] b, input logic [3:0] op);
    for (int i = 0; i < 4; i++) exp_q.push_back(a[8*i +: 8]);
    for (int i = 0; i < 4; i++) exp_q.push_back(b[8*i +: 8]);
    exp_q.push_back({4'h0, op});
    for (int i = 0; i < 3; i++) exp_q.push_back(8'h00);
  endtask

  // Pulse start for one edge; returns the cycle number of the accept (first start-bit cycle)
  task automatic begin_frame(input int sel, input logic [31:0] a, input logic [31:0] b,
                             input logic [3:0] op, output int c0);
    @(negedge clk);
    a_in = a; b_in = b; op_in = op;
    set_start(sel, 1'b1);
    push_frame(a, b, op);
    @(negedge clk);
    set_start(sel, 1'b0);
    c0 = cyc;
    busy_cyc = (get_busy(sel) === 1'b1) ? 1 : 0;
    total++;
    if (get_busy(sel) !== 1'b1 || get_tx(sel) !== 1'b0) begin
      bad++;
      $display("FAIL accept_%0d busy=%b tx=%b required busy=1 tx=0", sel, get_busy(sel), get_tx(sel));
    end
  endtask

  // Decode 12 bytes against the scoreboard and check start-bit and done timing from c0
  task automatic recv_frame(input int sel, input int t, input int g, input int c0);
    int w, s;
    logic [7:0] data, exp_b;
    for (int j = 0; j < 12; j++) begin
      w = 0;
      while (get_tx(sel) !== 1'b0 && w < 20 * t + 2 * g + 10) begin step(sel); w++; end
      if (get_tx(sel) !== 1'b0) begin
        total++; bad++;
        $display("FAIL start_timeout_%0d byte=%0d no start bit within %0d cycles", sel, j, w);
        return;
      end
      s = cyc;
      total++;
      if (s - c0 != j * (10 * t + g)) begin
        bad++;
        $display("FAIL start_time_%0d byte=%0d offset=%0d required=%0d", sel, j, s - c0, j * (10 * t + g));
      end
      total++;
      if (get_idx(sel) !== 4'(j)) begin
        bad++;
        $display("FAIL byte_idx_%0d got=%0d required=%0d", sel, get_idx(sel), j);
      end
      repeat (t / 2) step(sel);
      for (int n = 0; n < 8; n++) begin
        repeat (t) step(sel);
        data[n] = get_tx(sel);
      end
      repeat (t) step(sel);
      total++;
      if (get_tx(sel) !== 1'b1) begin
        bad++;
        $display("FAIL stop_bit_%0d byte=%0d got=%b required=1", sel, j, get_tx(sel));
      end
      exp_b = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
      total++;
      if (data !== exp_b) begin
        bad++;
        $display("FAIL data_%0d byte=%0d got=%h required=%h", sel, j, data, exp_b);
      end
    end
    w = 0;
    while (get_done(sel) !== 1'b1 && w < 10 * t) begin step(sel); w++; end
    total++;
    if (get_done(sel) !== 1'b1 || cyc - c0 != 120 * t + 11 * g) begin
      bad++;
      $display("FAIL done_time_%0d done=%b offset=%0d required=%0d", sel, get_done(sel), cyc - c0, 120 * t + 11 * g);
    end
    total++;
    if (busy_cyc != 120 * t + 11 * g || get_busy(sel) !== 1'b0) begin
      bad++;
      $display("FAIL busy_len_%0d got=%0d busy_now=%b required=%0d busy_now=0", sel, busy_cyc, get_busy(sel), 120 * t + 11 * g);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if ({tx0, tx1, tx2, busy0, busy1, busy2, done0, done1, done2} !== 9'b111_000_000 ||
        {idx0, idx1, idx2} !== 12'h000) begin
      bad++;
      $display("FAIL reset tx=%b%b%b busy=%b%b%b done=%b%b%b idx=%h%h%h required tx=111 others 0",
               tx0, tx1, tx2, busy0, busy1, busy2, done0, done1, done2, idx0, idx1, idx2);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_all_ones;
    int c0;
    begin_frame(0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'h2, c0);
    recv_frame(0, 104, 104, c0);
  endtask

  task automatic test_pattern_no_gap;
    int c0;
    begin_frame(1, 32'h1234_5678, 32'h9ABC_DEF0, 4'hF, c0);
    recv_frame(1, 4, 0, c0);
  endtask

  task automatic test_start_ignored;
    int c0, extra;
    begin_frame(1, 32'hA5A5_0F0F, 32'h0102_0304, 4'h6, c0);
    fork
      recv_frame(1, 4, 0, c0);
      begin
        int w = 0;
        while (idx1 !== 4'd3 && w < 400) begin @(negedge clk); w++; end
        a_in = 32'hDEAD_BEEF; b_in = 32'hCAFE_F00D; op_in = 4'h1;
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
      end
    join
    extra = 0;
    repeat (40) begin
      @(negedge clk);
      if (busy1 === 1'b1 || tx1 !== 1'b1) extra++;
    end
    total++;
    if (extra != 0) begin
      bad++;
      $display("FAIL no_requeue active_cycles=%0d required=0", extra);
    end
  endtask

  task automatic test_reset_mid_frame;
    int c0, w, seen_done;
    begin_frame(1, 32'h1111_2222, 32'h3333_4444, 4'h5, c0);
    w = 0;
    while (idx1 !== 4'd5 && w < 400) begin @(negedge clk); w++; end
    repeat (4 + 3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total++;
    if (tx1 !== 1'b1 || busy1 !== 1'b0 || idx1 !== 4'd0 || done1 !== 1'b0) begin
      bad++;
      $display("FAIL mid_reset tx=%b busy=%b idx=%0d done=%b required tx=1 busy=0 idx=0 done=0",
               tx1, busy1, idx1, done1);
    end
    exp_q.delete();
    seen_done = 0;
    repeat (60) begin
      @(negedge clk);
      if (done1 === 1'b1 || busy1 === 1'b1) seen_done++;
    end
    total++;
    if (seen_done != 0) begin
      bad++;
      $display("FAIL abandoned_frame stray_cycles=%0d required=0", seen_done);
    end
    begin_frame(1, 32'h0000_0005, 32'h0000_0003, 4'h0, c0);
    recv_frame(1, 4, 0, c0);
  endtask

  task automatic test_back_to_back;
    int c0;
    logic [31:0] a, b;
    a = 32'h0BAD_F00D; b = 32'h7654_3210;
    @(negedge clk);
    a_in = a; b_in = b; op_in = 4'h3;
    push_frame(a, b, 4'h3);
    start2 = 1'b1;
    @(negedge clk);
    c0 = cyc;
    busy_cyc = 1;
    for (int f = 0; f < 3; f++) begin
      recv_frame(2, 4, 2, c0);
      a = a + 32'h0101_0101; b = b ^ 32'hFFFF_0000;
      a_in = a; b_in = b; op_in = 4'(f + 4);
      if (f < 2) push_frame(a, b, 4'(f + 4));
      total++;
      if (tx2 !== 1'b1 || busy2 !== 1'b0) begin
        bad++;
        $display("FAIL idle_after_done frame=%0d tx=%b busy=%b required tx=1 busy=0", f, tx2, busy2);
      end
      if (f == 2) start2 = 1'b0;
      @(negedge clk);
      if (f < 2) begin
        c0 = cyc;
        busy_cyc = 1;
        total++;
        if (busy2 !== 1'b1 || tx2 !== 1'b0) begin
          bad++;
          $display("FAIL reaccept frame=%0d busy=%b tx=%b required busy=1 tx=0", f, busy2, tx2);
        end
      end
    end
  endtask

  initial begin
    test_reset;
    test_all_ones;
    test_pattern_no_gap;
    test_start_ignored;
    test_reset_mid_frame;
    test_back_to_back;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
